// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared constants and helpers for the register-file write arbiter.
//   REG_N / REG_AW / REG_NREQ : default data width, address width, requester count
//   REG_ZERO_ADDR             : address of the hard-wired zero register (writes swallowed)
//   rr_next()                 : round-robin pointer update
package reg_arb_pkg;

  localparam int unsigned REG_N         = 32;
  localparam int unsigned REG_AW        = 5;
  localparam int unsigned REG_NREQ      = 4;
  localparam int unsigned REG_ZERO_ADDR = 0;

  // Pointer moves just past the winner; a winner index >= nreq means
  // "no winner" and the pointer holds.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned w,
                                          input int unsigned nreq);
    if (w >= nreq) return ptr;
    return (w + 1) % nreq;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side and register-bank-side signals of the
// shared register-file write port.
//   req      : per-requester write request (level, held until granted)
//   req_addr : flattened addresses, requester i at [i*AW +: AW]
//   req_data : flattened data, requester i at [i*N +: N]
//   gnt      : one-hot grant pulse
//   wr_en    : write strobe to the register bank
//   wr_addr  : write address
//   wr_data  : write data
// Modports: master = requester side, slave = arbiter side.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned N    = REG_N,
  parameter int unsigned NREQ = REG_NREQ,
  parameter int unsigned AW   = REG_AW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*N-1:0]  req_data;
  logic [NREQ-1:0]    gnt;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [N-1:0]       wr_data;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   elig  : eligible requester mask
//   ptr   : index searched first; search wraps modulo NREQ
//   valid : at least one eligible requester
//   sel   : one-hot winner
//   idx   : binary winner index
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   idx
);

  // First eligible bit at or after ptr (circular) wins.
  always_comb begin
    int unsigned j;
    valid = 1'b0;
    sel   = '0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!valid && elig[IW'(j)]) begin
        valid        = 1'b1;
        sel[IW'(j)]  = 1'b1;
        idx          = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the single register-file write port among NREQ
// requesters. One winner per cycle; grant, strobe, address and data are
// registered. Writes to the zero register are granted but not strobed.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : reg_write_arbiter_if.slave (req/req_addr/req_data in,
//         gnt/wr_en/wr_addr/wr_data out)
// Build option: define REG_ARB_FAIR_EN for round-robin arbitration;
// otherwise fixed priority with the lowest index winning.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N    = REG_N,
  parameter int unsigned NREQ = REG_NREQ,
  parameter int unsigned AW   = REG_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_write_arbiter_if.slave    bus
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [N-1:0]    wr_data_q, wr_data_d;

  logic [NREQ-1:0] elig;
  logic            pick_valid;
  logic [NREQ-1:0] pick_sel;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   search_ptr;
  logic [AW-1:0]   pick_addr;
  logic [N-1:0]    pick_data;

  // A requester being granted this cycle still has req high; mask it so the
  // same write is not accepted twice.
  assign elig = bus.req & ~gnt_q;

`ifdef REG_ARB_FAIR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // State register: round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Next-state: advance past the winner, hold when nobody is eligible
  always_comb begin
    ptr_d = ptr_q;
    ptr_d = IW'(rr_next(32'(ptr_q), pick_valid ? 32'(pick_idx) : NREQ, NREQ));
  end

  assign search_ptr = ptr_q;
`else
  // Fixed priority: search always starts at requester 0.
  assign search_ptr = '0;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .elig  (elig),
    .ptr   (search_ptr),
    .valid (pick_valid),
    .sel   (pick_sel),
    .idx   (pick_idx)
  );

  // Winner's address/data mux
  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_sel[i]) begin
        pick_addr = bus.req_addr[i*AW +: AW];
        pick_data = bus.req_data[i*N +: N];
      end
    end
  end

  // Output next-values: address/data hold when there is no winner
  always_comb begin
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pick_valid) begin
      gnt_d     = pick_sel;
      wr_en_d   = (pick_addr != AW'(REG_ZERO_ADDR));
      wr_addr_d = pick_addr;
      wr_data_d = pick_data;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: table-driven directed bench for reg_write_arbiter
// (N=32, NREQ=4, AW=5). Expected values follow REG_ARB_FAIR_EN when defined.
module tb_reg_write_arbiter;

  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 5;

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;
  localparam logic [31:0] D2 = 32'hC2C2_2222;
  localparam logic [31:0] D3 = 32'hD3D3_3333;
  localparam logic [31:0] DX = 32'hDEAD_BEEF;

  // Requester addresses: r0=1, r1=2, r2=5, r3=7; x0 variant puts r1 at 0
  localparam logic [19:0]  AB = {5'd7, 5'd5, 5'd2, 5'd1};
  localparam logic [19:0]  AX = {5'd7, 5'd5, 5'd0, 5'd1};
  localparam logic [127:0] DB = {D3, D2, D1, D0};
  localparam logic [127:0] DXV = {D3, D2, DX, D0};

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [3:0]   gnt;
    logic         wr_en;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
  } vec_t;

  logic clk;
  logic rst;

  reg_write_arbiter_if #(.N(N), .NREQ(NREQ), .AW(AW)) bus ();

  reg_write_arbiter #(.N(N), .NREQ(NREQ), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [19:0] a,
                     input logic [127:0] d, input logic [3:0] g, input logic e,
                     input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.rst = r; v.req = rq; v.addr = a; v.data = d;
    v.gnt = g; v.wr_en = e; v.waddr = wa; v.wdata = wd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_addr = AB;
    bus.req_data = DB;

    // Reset held with all requesting
    add(1, 4'b1111, AB, DB, 4'b0000, 0, 5'd0, 32'h0);
    add(1, 4'b1111, AB, DB, 4'b0000, 0, 5'd0, 32'h0);
    // First grant after release goes to requester 0
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
    add(0, 4'b0000, AB, DB, 4'b0000, 0, 5'd1, D0);
    // Lone requester 2: grant every other cycle
    add(0, 4'b0100, AB, DB, 4'b0100, 1, 5'd5, D2);
    add(0, 4'b0100, AB, DB, 4'b0000, 0, 5'd5, D2);
    add(0, 4'b0100, AB, DB, 4'b0100, 1, 5'd5, D2);
    add(0, 4'b0100, AB, DB, 4'b0000, 0, 5'd5, D2);
    add(0, 4'b0000, AB, DB, 4'b0000, 0, 5'd5, D2);
    // x0 write: granted, not strobed, address/data still registered
    add(0, 4'b0010, AX, DXV, 4'b0010, 0, 5'd0, DX);
    add(0, 4'b0000, AX, DXV, 4'b0000, 0, 5'd0, DX);
`ifdef REG_ARB_FAIR_EN
    // Pointer moved to 2 after the x0 grant
    add(0, 4'b1111, AB, DB, 4'b0100, 1, 5'd5, D2);
    add(0, 4'b0000, AB, DB, 4'b0000, 0, 5'd5, D2);
`else
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
    add(0, 4'b0000, AB, DB, 4'b0000, 0, 5'd1, D0);
`endif
    add(1, 4'b0000, AB, DB, 4'b0000, 0, 5'd0, 32'h0);
`ifdef REG_ARB_FAIR_EN
    // All held: 0,1,2,3 then wrap to 0
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
    add(0, 4'b1111, AB, DB, 4'b0010, 1, 5'd2, D1);
    add(0, 4'b1111, AB, DB, 4'b0100, 1, 5'd5, D2);
    add(0, 4'b1111, AB, DB, 4'b1000, 1, 5'd7, D3);
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
`else
    // All held: 0 and 1 alternate through the self-mask
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
    add(0, 4'b1111, AB, DB, 4'b0010, 1, 5'd2, D1);
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
    add(0, 4'b1111, AB, DB, 4'b0010, 1, 5'd2, D1);
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
`endif
    // req=1010: requester 3 only wins while requester 1 is masked
    add(0, 4'b1010, AB, DB, 4'b0010, 1, 5'd2, D1);
    add(0, 4'b1010, AB, DB, 4'b1000, 1, 5'd7, D3);
    add(0, 4'b1010, AB, DB, 4'b0010, 1, 5'd2, D1);
    add(0, 4'b1010, AB, DB, 4'b1000, 1, 5'd7, D3);
    // Reset while gnt=0100; pending requests restart at requester 0
    add(0, 4'b0100, AB, DB, 4'b0100, 1, 5'd5, D2);
    add(1, 4'b1111, AB, DB, 4'b0000, 0, 5'd0, 32'h0);
    add(0, 4'b1111, AB, DB, 4'b0001, 1, 5'd1, D0);
    add(0, 4'b0000, AB, DB, 4'b0000, 0, 5'd1, D0);

    foreach (vecs[i]) begin
      rst          = vecs[i].rst;
      bus.req      = vecs[i].req;
      bus.req_addr = vecs[i].addr;
      bus.req_data = vecs[i].data;
      step();
      chk("gnt",     i, 64'(bus.gnt),     64'(vecs[i].gnt));
      chk("wr_en",   i, 64'(bus.wr_en),   64'(vecs[i].wr_en));
      chk("wr_addr", i, 64'(bus.wr_addr), 64'(vecs[i].waddr));
      chk("wr_data", i, 64'(bus.wr_data), 64'(vecs[i].wdata));
    end

    // Two persistent requesters after reset: no bubbles, alternate 0,2,0,2
    rst          = 1'b1;
    bus.req      = 4'b0101;
    bus.req_addr = AB;
    bus.req_data = DB;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("b2b_gnt",   100 + k, 64'(bus.gnt),     (k % 2 == 0) ? 64'h1 : 64'h4);
      chk("b2b_wr_en", 100 + k, 64'(bus.wr_en),   64'h1);
      chk("b2b_addr",  100 + k, 64'(bus.wr_addr), (k % 2 == 0) ? 64'd1 : 64'd5);
      chk("b2b_data",  100 + k, 64'(bus.wr_data), (k % 2 == 0) ? 64'(D0) : 64'(D2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
